// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Latency: req sampled at edge T, memory access during cycle T+1, ack during cycle T+2.
// Backpressure: requesters hold req/we/addr/wdata until ack; one access per 3 cycles max.
//
// Ports:
//   clock, reset_n                 single clock, synchronous active-low reset
//   req/we/addr/wdata{0,1}         request side, port 0 = CPU, port 1 = debug/DMA
//   ack/err/rdata{0,1}             one-cycle completion strobe, misalign flag, read data
//   mem_address, mem_MemWrite,     data memory side; controls are only active
//   mem_MemRead, mem_WriteData,    during ACCESS, and mem_ReadData is valid by the
//   mem_ReadData                   posedge that closes ACCESS
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [DATA_W-1:0] mem_WriteData,
    input  logic [DATA_W-1:0] mem_ReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Request captured when the arbiter leaves IDLE; the requester's live
    // inputs are ignored from then on.
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_port;

    // Port served most recently; reset marks port 1 so port 0 wins the first tie.
    logic                last_port;

    logic                grant_vld;
    logic                grant_port;
    logic                misaligned;

    assign misaligned = (lat_addr[1:0] != 2'b00);

    // Round-robin pick: a lone requester always wins, a tie goes to the port
    // that was not served last.
    always_comb begin
        grant_vld  = req0 | req1;
        grant_port = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_port;
        end else begin
            grant_port = req1;
        end
    end

    // Next state and memory-side outputs.
    always_comb begin
        state_nxt     = state;
        mem_address   = '0;
        mem_WriteData = '0;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt     = RESP;
                mem_address   = lat_addr;
                mem_WriteData = lat_wdata;
                // Misaligned accesses still spend the ACCESS cycle but never
                // touch memory. reset_n gates the strobes so a reset landing
                // in ACCESS cannot commit a write on that edge.
                if (!misaligned) begin
                    mem_MemWrite = lat_we & reset_n;
                    mem_MemRead  = ~lat_we & reset_n;
                end
            end
            RESP: begin
                // Unconditional return: a req still high here is stale and is
                // only looked at again in IDLE.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_port  <= 1'b0;
            last_port <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= state_nxt;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;

            if ((state == IDLE) && grant_vld) begin
                lat_we    <= grant_port ? we1    : we0;
                lat_addr  <= grant_port ? addr1  : addr0;
                lat_wdata <= grant_port ? wdata1 : wdata0;
                lat_port  <= grant_port;
                last_port <= grant_port;
            end

            // The edge closing ACCESS loads the response registers so ack,
            // err and rdata are all valid together throughout RESP.
            if (state == ACCESS) begin
                if (lat_port == 1'b0) begin
                    ack0 <= 1'b1;
                    err0 <= misaligned;
                end else begin
                    ack1 <= 1'b1;
                    err1 <= misaligned;
                end
                if (!lat_we && !misaligned) begin
                    if (lat_port == 1'b0) begin
                        rdata0 <= mem_ReadData;
                    end else begin
                        rdata1 <= mem_ReadData;
                    end
                end
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 7, byte-address width; DATA_W, default 32, data width.
REQ-002 SHALL have the following ports:
  clock  input  1  single clock; all state updates on posedge.
  reset_n  input  1  synchronous active-low reset.
  req0, req1  input  1  access request, port 0 (CPU) and port 1 (debug/DMA).
  we0, we1  input  1  1 = write, 0 = read.
  addr0, addr1  input  ADDR_W  byte address.
  wdata0, wdata1  input  DATA_W  write data.
  ack0, ack1  output  1  one-cycle completion strobe.
  err0, err1  output  1  misaligned-address flag, valid with ack.
  rdata0, rdata1  output  DATA_W  read data, valid with ack.
  mem_address  output  ADDR_W  to data memory address.
  mem_MemWrite, mem_MemRead  output  1  to data memory.
  mem_WriteData  output  DATA_W  to data memory.
  mem_ReadData  input  DATA_W  from data memory; the memory updates it on negedge while MemRead = 1.

Function
REQ-003 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-004 In IDLE, if any req is high at posedge, SHALL latch the winner's we, addr and wdata, record the winner, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with a single requester, grant it; with both requesting, grant the port not served last. After reset, port 0 wins the first tie.
REQ-006 The last-served pointer SHALL update only on entry to ACCESS.
REQ-007 In ACCESS, SHALL drive mem_address, mem_WriteData and mem_MemWrite = we / mem_MemRead = ~we from the latched request. The memory controls SHALL be 0 in every other state.
REQ-008 In ACCESS, SHALL capture mem_ReadData into an internal read register at the closing posedge for reads, then go to RESP.
REQ-009 In RESP, SHALL assert ack of the granted port for exactly one cycle, with the matching rdata (reads) and err, then return to IDLE.
REQ-010 The non-granted port's ack and err SHALL stay 0.
REQ-011 rdata of a port SHALL hold its last value until that port's next read ack. Write acks SHALL leave rdata unchanged.
REQ-012 Latency SHALL be: req sampled in IDLE at edge T -> ACCESS during cycle T+1 -> ack during cycle T+2. Maximum throughput is one access per 3 cycles.
REQ-013 Requesters SHALL hold req, we, addr and wdata stable until ack. The arbiter SHALL ignore changes after latching.
REQ-014 A requester whose req is still high during its RESP cycle SHALL NOT be re-granted from that stale cycle; the IDLE sample that follows is a new request.
REQ-015 For a misaligned address (addr[1:0] != 0), SHALL still pass ACCESS with both memory controls held 0, then ack with err = 1 and rdata unchanged.
REQ-016 With both ports continuously requesting, grants SHALL alternate 0,1,0,1. No port SHALL wait more than one other access.
REQ-017 A request deasserted in IDLE before being sampled SHALL produce no access.

Reset
REQ-018 When reset_n = 0 at posedge, SHALL go to IDLE and clear all of: ack0/1, err0/1, rdata0/1 (to 0), the latched request, and the last-served pointer (port 1 marked last, so port 0 wins).
REQ-019 mem_MemWrite and mem_MemRead SHALL be gated combinationally by reset_n, so reset asserted during ACCESS suppresses the write at that edge.
REQ-020 An access interrupted by reset SHALL produce no ack.

Verification
REQ-021 Single read: with Mem[1] = 200, req0 = 1, we0 = 0, addr0 = 4 -> ack0 two cycles after the sample edge, rdata0 = 200, err0 = 0, mem_MemRead high for exactly one cycle.
REQ-022 Write then read: port 1 writes 0xDEADBEEF to addr 8, then port 1 reads addr 8 -> two ack1 pulses, the second with rdata1 = 0xDEADBEEF. Memory locations other than the one at addr 8 are unchanged.
REQ-023 Contention: req0 and req1 both held continuously after reset for 4 accesses -> ack order 0,1,0,1, one ack every 3 cycles, no simultaneous acks.
REQ-024 Misaligned: req0 read at addr 6 -> ack0 with err0 = 1, rdata0 unchanged, mem_MemRead and mem_MemWrite never asserted.
REQ-025 Reset mid-operation: assert reset_n = 0 during the ACCESS cycle of a write of 0x55 to addr 12 -> Mem at word 3 keeps its prior value (400), no ack, FSM in IDLE. The next tie is granted to port 0.
